control_unit: RTL
=================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port clk  in  1  single system clock, all state updates on rising edge.
REQ-002 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port opcode  in  6  instruction bits [31:26].
REQ-004 SHALL have port funct  in  6  instruction bits [5:0].
REQ-005 SHALL have port btn  in  1  asynchronous board confirm button, active-high.
REQ-006 SHALL have outputs halt 1, sreg 1, smux5 1, smux16 2, smux32 1, smuxPC 3, salu 4, smem 1, sdisplay 1, smemtoreg 1: datapath strobes.
REQ-007 SHALL have output state  out  2  current FSM state, for debug.

Function
REQ-008 SHALL implement the states RUN=0, LOAD=1, WAIT_IN=2 and HALTED=3.
REQ-009 SHALL use the opcodes R=0x00, ADDI=0x01, SUBI=0x02, LW=0x03, SW=0x04, BEQ=0x05, BNE=0x06, J=0x07, IN=0x08, OUT=0x09 and HLT=0x3F; every other opcode SHALL execute as a NOP.
REQ-010 SHALL use these encodings:
- smuxPC: 0 PC+1, 1 branch-if-zero, 2 branch-if-not-zero, 3 jump-immediate, 4 jump-register.
- smux16: 0 immediate, 1 switches, 2 PC.
- smux5: 0 rd, 1 rt.
- smux32: 0 regB, 1 extended.
- smemtoreg: 0 ALU, 1 memory.
- salu: ADD=0, SUB=1.
REQ-011 SHALL, for R-type with funct<=0x0F, drive salu=funct[3:0], smux5=0, smux32=0, sreg=1 and smuxPC=0; funct=0x10 (JR) SHALL drive smuxPC=4 with sreg=0; any other funct SHALL be a NOP.
REQ-012 SHALL drive, for ADDI and SUBI, salu=ADD and SUB respectively, with smux32=1, smux16=0, smux5=1, sreg=1 and smuxPC=0.
REQ-013 SHALL drive, for SW, salu=ADD, smux32=1 and smem=1 for exactly one cycle; for OUT, salu=ADD, smux32=1 and sdisplay=1 for exactly one cycle.
REQ-014 SHALL drive, for BEQ, salu=SUB, smux32=0 and smuxPC=1; BNE SHALL be identical except smuxPC=2; J SHALL drive smuxPC=3.
REQ-015 SHALL, for LW in RUN, drive halt=1 with sreg=0 and move to LOAD; in LOAD it SHALL drive halt=0, sreg=1, smemtoreg=1, smux5=1, smux32=1, salu=ADD and smuxPC=0, then return to RUN, giving a 2-cycle latency.
REQ-016 SHALL, for IN in RUN, drive halt=1 and move to WAIT_IN.
REQ-017 SHALL hold halt=1 in WAIT_IN until a synchronized rising edge of btn; in the edge cycle it SHALL drive halt=0, sreg=1, smux16=1, smux32=1, smux5=1, salu=ADD and smuxPC=0, then go to RUN.
REQ-018 SHALL treat btn held high on entry to WAIT_IN as no edge; a new rising edge SHALL be required.
REQ-019 SHALL, for HLT, enter HALTED with halt=1 and all write strobes 0, and remain there until reset.
REQ-020 SHALL drive sreg=0, smem=0 and sdisplay=0 in every state and cycle not listed above; NOP SHALL be equivalent to smuxPC=0 with all write strobes 0.
REQ-021 SHALL compute outputs combinationally from state, opcode, funct and the btn edge, and SHALL NOT assert any write strobe for more than one cycle per instruction.

Reset
REQ-022 SHALL, while reset=0, force state=RUN, the synchronizer flops to 0, halt=1 and sreg=smem=sdisplay=0, independent of clk.
REQ-023 SHALL, on reset assertion in any state (LOAD, WAIT_IN, HALTED), abandon the pending operation without any register or memory write.

Structure
REQ-024 SHALL place the opcode, funct, state, salu, smuxPC and smux16 encodings in shared package cpu_pkg.
REQ-025 SHALL instantiate sub-module btn_sync: a 2-flop synchronizer plus a rising-edge detector producing a one-cycle pulse.

Verification
REQ-026 SHALL cover: R-type with funct=0x01 -> salu=1, sreg=1, smux5=0, halt=0 in the same cycle.
REQ-027 SHALL cover: LW -> cycle 1 halt=1, sreg=0; cycle 2 halt=0, sreg=1, smemtoreg=1; state sequence RUN, LOAD, RUN.
REQ-028 SHALL cover: IN with btn held high on entry, then low for 3 cycles, then high -> halt=1 throughout until the edge, then a single sreg=1, smux16=1 cycle, then RUN.
REQ-029 SHALL cover: HLT followed by 10 cycles of arbitrary opcodes -> halt stays 1, state=3; reset=0 -> state=0.
REQ-030 SHALL cover: reset asserted in WAIT_IN -> immediately halt=1 and sreg=0; after release, state=RUN with no write.
REQ-031 SHALL cover: undefined opcode 0x2A -> smuxPC=0 and sreg=smem=sdisplay=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the control unit: FSM states, opcodes, funct codes,
// ALU operations and datapath mux selects.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LOAD    = 2'd1,
    ST_WAIT_IN = 2'd2,
    ST_HALTED  = 2'd3
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h01;
  localparam logic [5:0] OP_SUBI = 6'h02;
  localparam logic [5:0] OP_LW   = 6'h03;
  localparam logic [5:0] OP_SW   = 6'h04;
  localparam logic [5:0] OP_BEQ  = 6'h05;
  localparam logic [5:0] OP_BNE  = 6'h06;
  localparam logic [5:0] OP_J    = 6'h07;
  localparam logic [5:0] OP_IN   = 6'h08;
  localparam logic [5:0] OP_OUT  = 6'h09;
  localparam logic [5:0] OP_HLT  = 6'h3F;

  // R-type funct values up to FN_ALU_MAX select the ALU op directly.
  localparam logic [5:0] FN_ALU_MAX = 6'h0F;
  localparam logic [5:0] FN_JR      = 6'h10;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;

  localparam logic [2:0] PC_INC = 3'd0;
  localparam logic [2:0] PC_BZ  = 3'd1;
  localparam logic [2:0] PC_BNZ = 3'd2;
  localparam logic [2:0] PC_JI  = 3'd3;
  localparam logic [2:0] PC_JR  = 3'd4;

  localparam logic [1:0] M16_IMM = 2'd0;
  localparam logic [1:0] M16_SW  = 2'd1;
  localparam logic [1:0] M16_PC  = 2'd2;

endpackage

// File: rtl/control_unit_if.sv
// Instruction fields into the control unit and datapath strobes out of it.
// master = control unit side, slave = datapath side.
interface control_unit_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       halt;
  logic       sreg;
  logic       smux5;
  logic [1:0] smux16;
  logic       smux32;
  logic [2:0] smuxPC;
  logic [3:0] salu;
  logic       smem;
  logic       sdisplay;
  logic       smemtoreg;

  modport master (
    input  opcode, funct,
    output halt, sreg, smux5, smux16, smux32, smuxPC, salu,
           smem, sdisplay, smemtoreg
  );

  modport slave (
    output opcode, funct,
    input  halt, sreg, smux5, smux16, smux32, smuxPC, salu,
           smem, sdisplay, smemtoreg
  );
endinterface

// File: rtl/btn_sync.sv
// Two-flop synchronizer for the board button followed by a rising-edge
// detector that emits a single-cycle pulse.
module btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);
  logic meta, sync, sync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= btn;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign rise = sync & ~sync_d;
endmodule

// File: rtl/control_unit.sv
// Multi-cycle CPU control unit: decodes opcode/funct into datapath strobes,
// stalls for loads and button-confirmed input, and parks on HLT.
module control_unit
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   btn,
  output state_t state,
  control_unit_if.master bus
);
  state_t state_q, next_state;
  logic   btn_rise;

  btn_sync u_btn_sync (
    .clk   (clk),
    .rst_n (reset),
    .btn   (btn),
    .rise  (btn_rise)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_RUN;
    else        state_q <= next_state;
  end

  assign state = state_q;

  always_comb begin
    next_state    = state_q;
    bus.halt      = 1'b0;
    bus.sreg      = 1'b0;
    bus.smux5     = 1'b0;
    bus.smux16    = M16_IMM;
    bus.smux32    = 1'b0;
    bus.smuxPC    = PC_INC;
    bus.salu      = ALU_ADD;
    bus.smem      = 1'b0;
    bus.sdisplay  = 1'b0;
    bus.smemtoreg = 1'b0;

    case (state_q)
      ST_RUN: begin
        case (bus.opcode)
          OP_R: begin
            if (bus.funct <= FN_ALU_MAX) begin
              bus.salu = bus.funct[3:0];
              bus.sreg = 1'b1;
            end else if (bus.funct == FN_JR) begin
              bus.smuxPC = PC_JR;
            end
          end
          OP_ADDI, OP_SUBI: begin
            bus.salu   = (bus.opcode == OP_SUBI) ? ALU_SUB : ALU_ADD;
            bus.smux32 = 1'b1;
            bus.smux5  = 1'b1;
            bus.sreg   = 1'b1;
          end
          OP_LW: begin
            bus.halt   = 1'b1;
            next_state = ST_LOAD;
          end
          OP_SW: begin
            bus.smux32 = 1'b1;
            bus.smem   = 1'b1;
          end
          OP_OUT: begin
            bus.smux32   = 1'b1;
            bus.sdisplay = 1'b1;
          end
          OP_BEQ, OP_BNE: begin
            bus.salu   = ALU_SUB;
            bus.smuxPC = (bus.opcode == OP_BNE) ? PC_BNZ : PC_BZ;
          end
          OP_J: bus.smuxPC = PC_JI;
          OP_IN: begin
            bus.halt   = 1'b1;
            next_state = ST_WAIT_IN;
          end
          OP_HLT: begin
            bus.halt   = 1'b1;
            next_state = ST_HALTED;
          end
          default: ;
        endcase
      end
      ST_LOAD: begin
        bus.sreg      = 1'b1;
        bus.smemtoreg = 1'b1;
        bus.smux5     = 1'b1;
        bus.smux32    = 1'b1;
        next_state    = ST_RUN;
      end
      ST_WAIT_IN: begin
        if (btn_rise) begin
          bus.sreg   = 1'b1;
          bus.smux16 = M16_SW;
          bus.smux32 = 1'b1;
          bus.smux5  = 1'b1;
          next_state = ST_RUN;
        end else begin
          bus.halt = 1'b1;
        end
      end
      ST_HALTED: bus.halt = 1'b1;
      default:   next_state = ST_RUN;
    endcase

    // Reset masks every write so an interrupted LOAD/WAIT_IN never commits.
    if (!reset) begin
      bus.halt     = 1'b1;
      bus.sreg     = 1'b0;
      bus.smem     = 1'b0;
      bus.sdisplay = 1'b0;
      next_state   = ST_RUN;
    end
  end
endmodule
